crc7: RTL and testbench
=======================

CRC7 -- requirements
Module: crc7

Interface
REQ-001 SHALL have parameter POLY, default 7'h09, meaning the generator polynomial x^7+x^3+1 with the implicit x^7 term omitted.
REQ-002 SHALL have parameter INIT, default 7'h00, meaning the register value loaded by reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clear, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: when high, the bit on bitval is shifted in on this edge.
REQ-006 SHALL have port bitval, input, 1 bit: serial message bit, MSB of the message first.
REQ-007 SHALL have port crc, output, 7 bits: current CRC register, crc[6] = x^6 coefficient.
REQ-008 SHALL have port crc_byte, output, 8 bits: {crc, 1'b1}, the SD-card CRC field plus end bit.
REQ-009 SHALL have port count, output, 6 bits: number of bits absorbed since the last clear, saturating at 63.
REQ-010 SHALL implement exactly the decided interface: one clock (clk); reset (clear) is synchronous and active-high.

Function
REQ-011 SHALL, on each rising clk edge with clear=0 and enable=1, compute fb = bitval XOR crc[6], then crc <= ({crc[5:0],1'b0}) XOR (fb ? POLY : 0).
REQ-012 SHALL, for the default POLY, give the next state as: crc[6:4] <= crc[5:3]; crc[3] <= crc[2]^fb; crc[2:1] <= crc[1:0]; crc[0] <= fb.
REQ-013 SHALL hold crc and count unchanged on any edge with clear=0 and enable=0.
REQ-014 SHALL sample enable and bitval only at the rising edge; one bit is absorbed per enabled cycle, with no latency beyond that edge.
REQ-015 SHALL update crc and crc_byte in the same edge as the absorbed bit; both are registered outputs, valid the cycle after the last enabled edge.
REQ-016 SHALL drive crc_byte combinationally from the crc register, with no extra register stage.
REQ-017 SHALL increment count on each enabled edge; at 63 it SHALL stay at 63 and the CRC SHALL still update.
REQ-018 SHALL require no framing: the CRC of an N-bit message is crc after N enabled edges following a clear.
REQ-019 SHALL give clear priority over enable when both are high on the same edge: the bit is discarded.
REQ-020 SHALL, when clear is asserted mid-message, discard all accumulated state on that edge; accumulation restarts on the next enabled edge.
REQ-021 SHALL contain no state machine beyond the CRC register and the counter; the block is stateless otherwise.

Reset
REQ-022 SHALL, on a rising edge with clear=1, set crc to INIT (0x00), crc_byte to 0x01, and count to 0.
REQ-023 SHALL hold all outputs at their reset values while clear stays high, regardless of enable and bitval.
REQ-024 SHALL define the power-up value as equal to the reset value, for simulation.

Structure
REQ-025 SHALL place the CRC7 polynomial constant (7'h09), the width constant (7) and the end-bit constant in the shared SD package, for reuse by the command sender.
REQ-026 SHALL be a single leaf module with no sub-modules; the next-state function may be a local function in the package.

Verification
REQ-027 SHALL cover: clear, then shift 40 bits 0x40_0000_0000 (CMD0, arg 0) -> crc=0x4A, crc_byte=0x95, count=40.
REQ-028 SHALL cover: clear, then shift 0x48_0000_01AA (CMD8) -> crc=0x43, crc_byte=0x87.
REQ-029 SHALL cover: clear, then shift 0x77_0000_0000 (CMD55) -> crc=0x32, crc_byte=0x65; then clear, shift 0x51_0000_0000 (CMD17) -> crc=0x2A, crc_byte=0x55.
REQ-030 SHALL cover: from 0x00, a single enabled 1 bit -> crc=0x09, count=1; follow with 5 cycles of enable=0 and toggling bitval -> crc stays 0x09, count stays 1.
REQ-031 SHALL cover: clear and enable both high mid-CMD0 -> crc=0x00, count=0; re-shifting CMD0 from the start -> 0x4A.
REQ-032 SHALL cover: 70 enabled zero bits after clear -> crc=0x00, count saturates at 63.

Source files
------------

// File: rtl/crc7_pkg.sv
// Shared SD constants for the CRC7 used on command frames, plus the
// single-bit CRC7 next-state function reused by the command sender.
package crc7_pkg;

  localparam int          CRC7_W        = 7;
  localparam logic [6:0]  CRC7_POLY     = 7'h09;
  localparam logic        SD_END_BIT    = 1'b1;
  localparam int          CRC7_CNT_W    = 6;
  localparam logic [5:0]  CRC7_CNT_MAX  = 6'd63;

  function automatic logic [CRC7_W-1:0] crc7_next(
    input logic [CRC7_W-1:0] cur,
    input logic              bit_in,
    input logic [CRC7_W-1:0] poly
  );
    logic fb;
    fb = bit_in ^ cur[CRC7_W-1];
    return {cur[CRC7_W-2:0], 1'b0} ^ (fb ? poly : {CRC7_W{1'b0}});
  endfunction

endpackage

// File: rtl/crc7.sv
// Serial CRC7 (MSB first) for SD command frames, with a saturating
// count of absorbed bits and the ready-to-send CRC byte {crc, end bit}.
module crc7
  import crc7_pkg::*;
#(
  parameter logic [CRC7_W-1:0] POLY = CRC7_POLY,
  parameter logic [CRC7_W-1:0] INIT = 7'h00
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  bitval,
  output logic [CRC7_W-1:0]     crc,
  output logic [CRC7_W:0]       crc_byte,
  output logic [CRC7_CNT_W-1:0] count
);

  // Declaration initialisers give simulation a power-up value equal to reset.
  logic [CRC7_W-1:0]     r_crc = INIT;
  logic [CRC7_CNT_W-1:0] r_count = 6'd0;
  logic [CRC7_W-1:0]     w_crc_next;
  logic [CRC7_CNT_W-1:0] w_count_next;

  // Next-state selection: clear wins over enable, otherwise hold.
  always_comb begin
    w_crc_next   = r_crc;
    w_count_next = r_count;
    if (clear) begin
      w_crc_next   = INIT;
      w_count_next = 6'd0;
    end else if (enable) begin
      w_crc_next = crc7_next(r_crc, bitval, POLY);
      if (r_count != CRC7_CNT_MAX) begin
        w_count_next = r_count + 6'd1;
      end else begin
        w_count_next = r_count;
      end
    end else begin
      w_crc_next   = r_crc;
      w_count_next = r_count;
    end
  end

  // State register: CRC and bit counter.
  always_ff @(posedge clk) begin
    r_crc   <= w_crc_next;
    r_count <= w_count_next;
  end

  assign crc      = r_crc;
  assign crc_byte = {r_crc, SD_END_BIT};
  assign count    = r_count;

endmodule

// File: tb/tb_crc7.sv
// Directed bench for crc7: SD command CRCs, hold, clear priority and
// counter saturation, with hand-computed expected values.
module tb_crc7;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic       bitval = 1'b0;
  logic [6:0] crc;
  logic [7:0] crc_byte;
  logic [5:0] count;

  int total = 0;
  int bad   = 0;

  crc7 dut (
    .clk      (clk),
    .clear    (clear),
    .enable   (enable),
    .bitval   (bitval),
    .crc      (crc),
    .crc_byte (crc_byte),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%02h expected=0x%02h", tag, got, exp);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    clear  = 1'b0;
  endtask

  // Shift the low n bits of msg, MSB first; returns at the negedge after the last absorb.
  task automatic shift_msg(input logic [39:0] msg, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      enable = 1'b1;
      bitval = msg[i];
    end
    @(negedge clk);
    enable = 1'b0;
    bitval = 1'b0;
  endtask

  task automatic shift_const(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      enable = 1'b1;
      bitval = b;
    end
    @(negedge clk);
    enable = 1'b0;
    bitval = 1'b0;
  endtask

  initial begin
    #1;
    chk("powerup_crc", {1'b0, crc}, 8'h00);
    chk("powerup_cnt", {2'b00, count}, 8'h00);

    do_clear();
    chk("reset_crc", {1'b0, crc}, 8'h00);
    chk("reset_byte", crc_byte, 8'h01);
    chk("reset_cnt", {2'b00, count}, 8'h00);

    // clear held high with enable and data active
    @(negedge clk);
    clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enable = 1'b1;
      bitval = i[0];
      @(negedge clk);
    end
    chk("clear_hold_crc", {1'b0, crc}, 8'h00);
    chk("clear_hold_cnt", {2'b00, count}, 8'h00);
    clear  = 1'b0;
    enable = 1'b0;

    // CMD0
    do_clear();
    shift_msg(40'h40_0000_0000, 40);
    chk("cmd0_crc", {1'b0, crc}, 8'h4A);
    chk("cmd0_byte", crc_byte, 8'h95);
    chk("cmd0_cnt", {2'b00, count}, 8'd40);

    // CMD8
    do_clear();
    shift_msg(40'h48_0000_01AA, 40);
    chk("cmd8_crc", {1'b0, crc}, 8'h43);
    chk("cmd8_byte", crc_byte, 8'h87);

    // CMD55 then CMD17
    do_clear();
    shift_msg(40'h77_0000_0000, 40);
    chk("cmd55_crc", {1'b0, crc}, 8'h32);
    chk("cmd55_byte", crc_byte, 8'h65);
    do_clear();
    shift_msg(40'h51_0000_0000, 40);
    chk("cmd17_crc", {1'b0, crc}, 8'h2A);
    chk("cmd17_byte", crc_byte, 8'h55);

    // single 1 bit, then disabled cycles with toggling data
    do_clear();
    shift_msg(40'h1, 1);
    chk("one_bit_crc", {1'b0, crc}, 8'h09);
    chk("one_bit_cnt", {2'b00, count}, 8'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      enable = 1'b0;
      bitval = ~bitval;
    end
    @(negedge clk);
    chk("hold_crc", {1'b0, crc}, 8'h09);
    chk("hold_cnt", {2'b00, count}, 8'd1);

    // clear and enable together mid-CMD0
    do_clear();
    shift_msg(40'h40_0000_0000 >> 20, 20);
    chk("mid_cnt_pre", {2'b00, count}, 8'd20);
    @(negedge clk);
    clear  = 1'b1;
    enable = 1'b1;
    bitval = 1'b1;
    @(negedge clk);
    clear  = 1'b0;
    enable = 1'b0;
    bitval = 1'b0;
    chk("mid_clear_crc", {1'b0, crc}, 8'h00);
    chk("mid_clear_cnt", {2'b00, count}, 8'd0);
    shift_msg(40'h40_0000_0000, 40);
    chk("reshift_cmd0", {1'b0, crc}, 8'h4A);

    // saturation
    do_clear();
    shift_const(1'b0, 70);
    chk("sat_crc", {1'b0, crc}, 8'h00);
    chk("sat_cnt", {2'b00, count}, 8'd63);
    shift_const(1'b1, 1);
    chk("sat_upd_crc", {1'b0, crc}, 8'h09);
    chk("sat_upd_cnt", {2'b00, count}, 8'd63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
